// File: rtl/imm_pkg.sv
// Shared definitions for immediate generation: major opcodes (inst[6:2]),
// the output format code and the supported datapath widths.
package imm_pkg;

    // Major opcodes, instruction bits [6:2]
    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    // Immediate format code presented on out_fmt
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_e;

    // Supported datapath widths
    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    function automatic bit xlen_is_legal(input int xlen);
        return (xlen == XLEN_32) || (xlen == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate decoder: raw instruction -> XLEN-wide
// immediate and format code. Everything is built at 64 bits and then
// truncated, which gives the same result as extending straight to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt
);

    generate
        if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
            $error("imm_decode: XLEN must be 32 or 64");
        end
    endgenerate

    logic [4:0]  opc;
    logic [63:0] imm_full;

    assign opc = inst[6:2];

    // Select the immediate layout from the major opcode; non-32-bit encodings decode as NONE
    always_comb begin
        imm_full = '0;
        fmt      = FMT_NONE;
        if (inst[1:0] == 2'b11) begin
            case (opc)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    imm_full = {{52{inst[31]}}, inst[31:20]};
                    fmt      = FMT_I;
                end
                OPC_OP_IMM_32: begin
                    // The W-suffixed ALU ops only exist on RV64
                    if (XLEN == XLEN_64) begin
                        imm_full = {{52{inst[31]}}, inst[31:20]};
                        fmt      = FMT_I;
                    end
                end
                OPC_STORE: begin
                    imm_full = {{52{inst[31]}}, inst[31:25], inst[11:7]};
                    fmt      = FMT_S;
                end
                OPC_BRANCH: begin
                    imm_full = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                                inst[11:8], 1'b0};
                    fmt      = FMT_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_full = {{32{inst[31]}}, inst[31:12], 12'b0};
                    fmt      = FMT_U;
                end
                OPC_JAL: begin
                    imm_full = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                                inst[30:21], 1'b0};
                    fmt      = FMT_J;
                end
                OPC_SYSTEM: begin
                    // Only the CSR*I forms (funct3[2] set) carry a uimm
                    if (EN_CSR_ZIMM && inst[14]) begin
                        imm_full = {59'b0, inst[19:15]};
                        fmt      = FMT_Z;
                    end
                end
                default: begin
                    imm_full = '0;
                    fmt      = FMT_NONE;
                end
            endcase
        end
    end

    assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes on the way in, then holds
// the result in an output register backed by a one-entry skid register so
// the stage sustains one result per cycle under backpressure.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on registered state (skid empty), never
// on out_ready. Once out_valid is raised, out_* stay unchanged until the
// cycle out_ready is high. Flush overrides everything and drops any input
// presented in that cycle.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int TAG_W       = 64,
    parameter bit EN_CSR_ZIMM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    imm_fmt_e         out_fmt_q,   out_fmt_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;

    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    imm_fmt_e         skid_fmt_q,   skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic             in_xfer;
    logic             out_free;

    imm_decode #(
        .XLEN        (XLEN),
        .EN_CSR_ZIMM (EN_CSR_ZIMM)
    ) u_decode (
        .inst (in_inst),
        .imm  (dec_imm),
        .fmt  (dec_fmt)
    );

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // Next-state for output and skid registers; skid is always the older entry
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = in_xfer;
                if (in_xfer) begin
                    skid_imm_d = dec_imm;
                    skid_fmt_d = dec_fmt;
                    skid_tag_d = in_tag;
                end
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_fmt_d   = dec_fmt;
            skid_tag_d   = in_tag;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_fmt   = out_fmt_q;
    assign out_tag   = out_tag_q;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, parametrised immediate-generation stage for the decode pipeline. It accepts a raw instruction word plus a sideband tag (PC or ROB index) over a valid/ready handshake and produces the XLEN-wide immediate and a format code one cycle later. A 2-entry skid buffer keeps full throughput under backpressure. It covers RV32I/RV64I (OP-IMM-32 included) and, optionally, the Zicsr zero-extended uimm, with flush support for branch redirect.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
TAG_W, 64, width of the sideband tag carried alongside the instruction.
EN_CSR_ZIMM, 1, when 1 SYSTEM opcodes produce the zero-extended uimm; when 0 they decode as NONE.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline flush; discards all held and incoming entries.
in_valid  input  1  instruction word valid.
in_ready  output  1  stage can accept this cycle.
in_inst  input  32  raw instruction word.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_imm=0, out_fmt=NONE, out_tag=0, skid empty, in_ready=1.
- Decoding uses opcode inst[6:2]; sgn = inst[31]; all sign extension is to XLEN.
  - OP-IMM 00100, LOAD 00000, JALR 11001, and OP-IMM-32 00110 (only when XLEN=64): I-type, imm = sext(inst[31:20]), fmt=I.
  - STORE 01000: imm = sext({inst[31:25],inst[11:7]}), fmt=S.
  - BRANCH 11000: imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}), fmt=B.
  - LUI 01101 and AUIPC 00101: imm = sext({inst[31:12],12'b0}), fmt=U. For XLEN=32 this is no extension.
  - JAL 11011: imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}), fmt=J.
  - SYSTEM 11100 with inst[14]=1 and EN_CSR_ZIMM=1: imm = zext(inst[19:15]), fmt=Z.
  - Anything else, including inst[1:0]!=11: imm=0, fmt=NONE. The entry still passes through.
- Latency: an accepted input appears on out_* exactly 1 cycle later if the output register is free.
- Handshake:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_ready = !skid_valid. It is a registered-state function only, with no combinational path from out_ready.
  - out_* hold stable while out_valid & !out_ready.
- Output register update each cycle:
  - When the output is empty or transferring, it loads from skid if skid is full, else from input if an input transfers, else out_valid becomes 0.
  - An input that transfers while the output is stalled goes to skid.
  - When skid drains into the output while an input transfers, the input goes to skid.
- Ordering: strict FIFO. The skid entry is always older than any new input.
- Flush has priority over everything. Next cycle out_valid=0 and skid is empty, and any input presented in the flush cycle is dropped. in_ready may be 1 during flush; the input is consumed and discarded. Data registers need not clear.
- Reset asserted mid-stream: all valid state is lost immediately. After rst_n rises, the first accepted instruction is out on the following cycle.
- Invalid parameter values (XLEN not 32/64): elaboration error.

Decomposition:
- Shared package imm_pkg holds:
  - opcode[6:2] constants, including OP-IMM-32 and SYSTEM;
  - the 3-bit format enum;
  - the legal XLEN values.
- Sub-module imm_decode (purely combinational: inst -> imm, fmt; parameters XLEN and EN_CSR_ZIMM) is reusable elsewhere.
- imm_gen_stage wraps it with the output register and skid buffer.

Test Plan:
- XLEN=64: addi 0xFFF00093 -> out_imm 0xFFFFFFFFFFFFFFFF, fmt I; lui 0x80000037 -> 0xFFFFFFFF80000000, fmt U; beq 0xFE000EE3 -> 0xFFFFFFFFFFFFFFFC, fmt B; jal 0x0080006F -> 0x8, fmt J. Each appears 1 cycle after acceptance.
- XLEN=32: lui 0x80000037 -> 0x80000000; sw 0xFE112E23 -> 0xFFFFFFFC, fmt S; OP-IMM-32 0xFFF0009B -> imm 0, fmt NONE.
- csrrwi 0x7C02D073 with EN_CSR_ZIMM=1 -> imm 0x5, fmt Z; with EN_CSR_ZIMM=0 -> imm 0, fmt NONE.
- Backpressure: stream 4 instructions with tags 1..4 back-to-back and out_ready=0 for 3 cycles.
  - in_ready drops after the 2nd acceptance.
  - out_* stay stable while stalled.
  - After release, tags emerge 1,2,3,4 with no loss or duplication.
  - Sustained out_ready=1 gives 1 result per cycle.
- Flush with output and skid both full and in_valid=1 -> next cycle out_valid=0 and in_ready=1. The next accepted tag is the first to appear.
- Assert rst_n low asynchronously between clock edges while out_valid=1 -> out_valid=0 immediately, outputs at reset values. Resumes correctly after release.
